// File: rtl/mem_dp_lat.sv
// mem_dp_lat: parametrised dual-port word memory with per-port latency.
//
// Port A is read-only. Port B reads or writes, with byte enables.
// Each port runs its own IDLE -> BUSY -> RESP -> IDLE state machine. A
// request is accepted only in IDLE, and the port answers LAT cycles after
// the accepting edge. The array is not reset, so its contents survive rst.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   read_a, address_a          port A request and byte address
//   resp_a, rdata_a            port A response strobe and read data
//   read_b, write_b, wmask_b   port B request type and byte enables
//   address_b, wdata_b         port B byte address and write data
//   resp_b, rdata_b            port B response strobe and read data
//
// state   | meaning
// --------+----------------------------------------------------
// IDLE    | waiting for a request; inputs are sampled only here
// BUSY    | latency down-counter running (skipped when LAT = 1)
// RESP    | resp high for one cycle, rdata valid

module mem_dp_lat #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024,
    parameter int LAT_A  = 1,
    parameter int LAT_B  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   read_a,
    input  logic [ADDR_W-1:0]      address_a,
    output logic                   resp_a,
    output logic [DATA_W-1:0]      rdata_a,
    input  logic                   read_b,
    input  logic                   write_b,
    input  logic [DATA_W/8-1:0]    wmask_b,
    input  logic [ADDR_W-1:0]      address_b,
    input  logic [DATA_W-1:0]      wdata_b,
    output logic                   resp_b,
    output logic [DATA_W-1:0]      rdata_b
);

    localparam int MASK_W  = DATA_W / 8;
    localparam int OFF_W   = $clog2(MASK_W);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int CNT_A_W = (LAT_A > 1) ? $clog2(LAT_A) : 1;
    localparam int CNT_B_W = (LAT_B > 1) ? $clog2(LAT_B) : 1;
    localparam bit SKIP_A  = (LAT_A == 1);
    localparam bit SKIP_B  = (LAT_B == 1);

    if (LAT_A < 1) begin : g_chk_lat_a
        $error("mem_dp_lat: LAT_A must be >= 1");
    end
    if (LAT_B < 1) begin : g_chk_lat_b
        $error("mem_dp_lat: LAT_B must be >= 1");
    end
    if ((DATA_W % 8) != 0) begin : g_chk_data_w
        $error("mem_dp_lat: DATA_W must be a multiple of 8");
    end
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("mem_dp_lat: DEPTH must be a power of two");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Offset bits and bits above the word index are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^{address_a, address_b};

    // ------------------------------------------------------------ port A
    state_e             state_a_q;
    logic [CNT_A_W-1:0] cnt_a_q;
    logic [IDX_W-1:0]   idx_a_q;
    logic [DATA_W-1:0]  rdata_a_q;
    logic [IDX_W-1:0]   idx_a_d;
    logic               enter_a;

    // In IDLE the live address is used, since with LAT=1 the array is
    // sampled on the accepting edge itself.
    always_comb begin
        idx_a_d = idx_a_q;
        enter_a = 1'b0;
        if (state_a_q == ST_IDLE) begin
            idx_a_d = address_a[OFF_W +: IDX_W];
            enter_a = read_a && SKIP_A;
        end else if (state_a_q == ST_BUSY) begin
            enter_a = (cnt_a_q == CNT_A_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_a_q <= ST_IDLE;
            cnt_a_q   <= '0;
            idx_a_q   <= '0;
            rdata_a_q <= '0;
        end else begin
            if (enter_a) begin
                rdata_a_q <= mem_q[idx_a_d];
            end
            unique case (state_a_q)
                ST_IDLE: begin
                    if (read_a) begin
                        idx_a_q   <= idx_a_d;
                        cnt_a_q   <= CNT_A_W'(LAT_A - 1);
                        state_a_q <= SKIP_A ? ST_RESP : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt_a_q <= cnt_a_q - CNT_A_W'(1);
                    if (cnt_a_q == CNT_A_W'(1)) begin
                        state_a_q <= ST_RESP;
                    end
                end
                ST_RESP: state_a_q <= ST_IDLE;
                default: state_a_q <= ST_IDLE;
            endcase
        end
    end

    assign resp_a  = (state_a_q == ST_RESP);
    assign rdata_a = rdata_a_q;

    // ------------------------------------------------------------ port B
    state_e             state_b_q;
    logic [CNT_B_W-1:0] cnt_b_q;
    logic [IDX_W-1:0]   idx_b_q;
    logic               wr_b_q;
    logic [MASK_W-1:0]  mask_b_q;
    logic [DATA_W-1:0]  wdata_b_q;
    logic [DATA_W-1:0]  rdata_b_q;
    logic [IDX_W-1:0]   idx_b_d;
    logic               wr_b_d;
    logic [MASK_W-1:0]  mask_b_d;
    logic [DATA_W-1:0]  wdata_b_d;
    logic               enter_b;
    logic               commit_b;

    // A combined read+write is a write; rdata still carries the old word
    // because the array read and the commit share the same edge.
    always_comb begin
        idx_b_d   = idx_b_q;
        wr_b_d    = wr_b_q;
        mask_b_d  = mask_b_q;
        wdata_b_d = wdata_b_q;
        enter_b   = 1'b0;
        if (state_b_q == ST_IDLE) begin
            idx_b_d   = address_b[OFF_W +: IDX_W];
            wr_b_d    = write_b;
            mask_b_d  = wmask_b;
            wdata_b_d = wdata_b;
            enter_b   = (read_b || write_b) && SKIP_B;
        end else if (state_b_q == ST_BUSY) begin
            enter_b = (cnt_b_q == CNT_B_W'(1));
        end
    end

    // rst gates the commit so a LAT=1 write presented during reset is dropped.
    assign commit_b = enter_b && wr_b_d && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_b_q <= ST_IDLE;
            cnt_b_q   <= '0;
            idx_b_q   <= '0;
            wr_b_q    <= 1'b0;
            mask_b_q  <= '0;
            wdata_b_q <= '0;
            rdata_b_q <= '0;
        end else begin
            if (enter_b) begin
                rdata_b_q <= mem_q[idx_b_d];
            end
            unique case (state_b_q)
                ST_IDLE: begin
                    if (read_b || write_b) begin
                        idx_b_q   <= idx_b_d;
                        wr_b_q    <= wr_b_d;
                        mask_b_q  <= mask_b_d;
                        wdata_b_q <= wdata_b_d;
                        cnt_b_q   <= CNT_B_W'(LAT_B - 1);
                        state_b_q <= SKIP_B ? ST_RESP : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt_b_q <= cnt_b_q - CNT_B_W'(1);
                    if (cnt_b_q == CNT_B_W'(1)) begin
                        state_b_q <= ST_RESP;
                    end
                end
                ST_RESP: state_b_q <= ST_IDLE;
                default: state_b_q <= ST_IDLE;
            endcase
        end
    end

    assign resp_b  = (state_b_q == ST_RESP);
    assign rdata_b = rdata_b_q;

    // Array write port; port A reads on the same edge see the old word.
    always_ff @(posedge clk) begin
        if (commit_b) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (mask_b_d[i]) begin
                    mem_q[idx_b_d][8*i +: 8] <= wdata_b_d[8*i +: 8];
                end
            end
        end
    end

endmodule
